// File: rtl/piso_bit_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out bit serializer:
// state encodings, default word length and a constant log2 helper.
package piso_bit_serializer_pkg;

  // Gray-coded: IDLE and SHIFT differ in a single bit; 2'b1x are illegal.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Number of bits needed to count 0..value-1 (at least 1).
  function automatic int clog2_int(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes a WIDTH-bit word over valid/ready and
// shifts it out MSB-first, one bit per enabled clock, feeding the 1010 detector.
module piso_bit_serializer
  import piso_bit_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             d_out,
  output logic             d_out_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = clog2_int(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Handshake: a word transfers on a rising edge where load_valid && load_ready.
  // load_valid may rise at any time; the source must hold data_in stable until
  // it sees load_ready, and a word offered while load_ready=0 is not captured.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

  always_comb begin
    load_ready = 1'b0;
    if (state_q == ST_IDLE) begin
      load_ready = 1'b1;
    end else if (last_bit && shift_en) begin
      // The final bit leaves this edge, so a new word can land with no gap.
      load_ready = 1'b1;
    end
  end

  assign accept = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SHIFT;
          sh_d    = data_in;
          cnt_d   = CNT_LAST;
        end
      end
      ST_SHIFT: begin
        if (shift_en) begin
          if (cnt_q != '0) begin
            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            cnt_d = cnt_q - 1'b1;
          end else if (accept) begin
            sh_d  = data_in;
            cnt_d = CNT_LAST;
          end else begin
            state_d = ST_IDLE;
            sh_d    = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  assign d_out       = sh_q[WIDTH-1];
  assign busy        = (state_q == ST_SHIFT);
  assign d_out_valid = busy;
  assign frame_done  = last_bit;

endmodule
